// File: rtl/bp_dm_arbiter.sv
// Round-robin arbiter for bp's single-port data memory: port 0 (CPU) vs port 1 (loader/debug).
// A port may lock ownership for up to MAX_BURST consecutive grants while the other port waits.
module bp_dm_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state;
  logic          last;
  logic [BW-1:0] bcnt;
  logic          rv0, rv1;

  // Owner keeps the port while under its burst budget; otherwise plain round-robin.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      if (state == OWN0 && req0 && bcnt < BMAX)      gnt0 = 1'b1;
      else if (state == OWN1 && req1 && bcnt < BMAX) gnt1 = 1'b1;
      else if (req0 && !req1)                        gnt0 = 1'b1;
      else if (req1 && !req0)                        gnt1 = 1'b1;
      else if (req0 && req1) begin
        if (last) gnt0 = 1'b1;
        else      gnt1 = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = gnt0 | gnt1;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  assign rvalid0 = rv0;
  assign rvalid1 = rv1;
  assign rdata   = mem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      last  <= 1'b1;
      bcnt  <= '0;
      rv0   <= 1'b0;
      rv1   <= 1'b0;
    end else begin
      rv0 <= gnt0 & ~we0;
      rv1 <= gnt1 & ~we1;
      if (gnt0) begin
        last  <= 1'b0;
        state <= (lock0 && req1) ? OWN0 : IDLE;
        bcnt  <= (state == OWN0) ? bcnt + 1'b1 : BW'(1);
      end else if (gnt1) begin
        last  <= 1'b1;
        state <= (lock1 && req0) ? OWN1 : IDLE;
        bcnt  <= (state == OWN1) ? bcnt + 1'b1 : BW'(1);
      end else begin
        state <= IDLE;
        bcnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bp_dm_arbiter.sv
// Directed vector bench for bp_dm_arbiter: a vector table plus hand-written reset sequences.
module tb_bp_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  bp_dm_arbiter #(.AW(8), .DW(16), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        r0, r1, w0, w1, l0, l1;
    logic [7:0]  a0, a1;
    logic [15:0] d0, d1;
    logic        g0, g1, rv0, rv1;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r0, logic r1, logic w0, logic w1, logic l0, logic l1,
                              logic [7:0] a0, logic [7:0] a1, logic [15:0] d0, logic [15:0] d1,
                              logic g0, logic g1, logic rv0, logic rv1);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1; v.l0 = l0; v.l1 = l1;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.rv0 = rv0; v.rv1 = rv1;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    req0 = v.r0; req1 = v.r1; we0 = v.w0; we1 = v.w1; lock0 = v.l0; lock1 = v.l1;
    addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
  endtask

  task automatic idle_inputs();
    drive(mk(0,0,0,0,0,0,8'h10,8'h20,16'h0,16'h0,0,0,0,0));
  endtask

  initial begin
    logic        e_we;
    logic [7:0]  e_addr;
    logic [15:0] e_wd;

    rst = 1'b0;
    mem_rdata = 16'h0;
    idle_inputs();

    // Requests during reset must not be granted.
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1;
    #1;
    check("rst_gnt0", 16'(gnt0), 16'h0);
    check("rst_gnt1", 16'(gnt1), 16'h0);
    check("rst_mem_en", 16'(mem_en), 16'h0);
    check("rst_mem_we", 16'(mem_we), 16'h0);
    check("rst_rvalid", {14'h0, rvalid1, rvalid0}, 16'h0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;

    //        r0 r1 w0 w1 l0 l1  a0     a1     d0       d1        g0 g1 rv0 rv1
    vt.push_back(mk(0,0,0,0,0,0, 8'h10, 8'h20, 16'h0,   16'h0,    0,0, 0,0)); // idle
    vt.push_back(mk(1,0,0,0,0,0, 8'h10, 8'h20, 16'h0,   16'h0,    1,0, 0,0)); // single read
    vt.push_back(mk(0,0,0,0,0,0, 8'h10, 8'h20, 16'h0,   16'h0,    0,0, 1,0)); // rvalid0
    vt.push_back(mk(1,1,0,0,0,0, 8'h11, 8'h21, 16'h0,   16'h0,    0,1, 0,0)); // tie, last=0
    vt.push_back(mk(1,1,0,0,0,0, 8'h11, 8'h21, 16'h0,   16'h0,    1,0, 0,1));
    vt.push_back(mk(1,1,0,0,0,0, 8'h11, 8'h21, 16'h0,   16'h0,    0,1, 1,0));
    vt.push_back(mk(1,1,0,0,0,0, 8'h11, 8'h21, 16'h0,   16'h0,    1,0, 0,1));
    vt.push_back(mk(0,1,0,1,0,0, 8'h11, 8'hFF, 16'h0,   16'h1234, 0,1, 1,0)); // write
    vt.push_back(mk(0,0,0,0,0,0, 8'h11, 8'hFF, 16'h0,   16'h0,    0,0, 0,0)); // no rvalid after write
    vt.push_back(mk(1,0,0,0,0,0, 8'h12, 8'h22, 16'h0,   16'h0,    1,0, 0,0)); // make last=0
    vt.push_back(mk(1,1,0,0,0,1, 8'h12, 8'h22, 16'h0,   16'h0,    0,1, 1,0)); // burst 1
    vt.push_back(mk(1,1,0,0,0,1, 8'h12, 8'h22, 16'h0,   16'h0,    0,1, 0,1)); // burst 2
    vt.push_back(mk(1,1,0,0,0,1, 8'h12, 8'h22, 16'h0,   16'h0,    0,1, 0,1)); // burst 3
    vt.push_back(mk(1,1,0,0,0,1, 8'h12, 8'h22, 16'h0,   16'h0,    0,1, 0,1)); // burst 4
    vt.push_back(mk(1,1,0,0,0,1, 8'h12, 8'h22, 16'h0,   16'h0,    1,0, 0,1)); // limit: port 0
    vt.push_back(mk(1,1,0,0,0,1, 8'h12, 8'h22, 16'h0,   16'h0,    0,1, 1,0)); // port 1 resumes
    vt.push_back(mk(1,1,0,0,0,1, 8'h13, 8'h23, 16'h0,   16'h0,    0,1, 0,1)); // 2nd locked grant
    vt.push_back(mk(1,0,0,0,0,0, 8'h13, 8'h23, 16'h0,   16'h0,    1,0, 0,1)); // req1 drops
    vt.push_back(mk(0,0,0,0,0,0, 8'h13, 8'h23, 16'h0,   16'h0,    0,0, 1,0));
    vt.push_back(mk(1,0,1,0,1,0, 8'h14, 8'h24, 16'hBEEF,16'h0,    1,0, 0,0)); // lock, no rival
    vt.push_back(mk(1,0,0,0,1,0, 8'h14, 8'h24, 16'h0,   16'h0,    1,0, 0,0));
    vt.push_back(mk(1,1,0,0,1,0, 8'h14, 8'h24, 16'h0,   16'h0,    0,1, 1,0)); // no ownership held
    vt.push_back(mk(0,0,0,0,0,0, 8'h14, 8'h24, 16'h0,   16'h0,    0,0, 0,1));

    for (int unsigned i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      drive(vt[i]);
      mem_rdata = 16'hA5A5 ^ 16'(i);
      #1;
      e_we = 1'b0; e_addr = 8'h0; e_wd = 16'h0;
      if (vt[i].g0)      begin e_we = vt[i].w0; e_addr = vt[i].a0; e_wd = vt[i].d0; end
      else if (vt[i].g1) begin e_we = vt[i].w1; e_addr = vt[i].a1; e_wd = vt[i].d1; end
      check($sformatf("v%0d_gnt0", i), 16'(gnt0), 16'(vt[i].g0));
      check($sformatf("v%0d_gnt1", i), 16'(gnt1), 16'(vt[i].g1));
      check($sformatf("v%0d_mem_en", i), 16'(mem_en), 16'(vt[i].g0 | vt[i].g1));
      check($sformatf("v%0d_mem_we", i), 16'(mem_we), 16'(e_we));
      check($sformatf("v%0d_mem_addr", i), 16'(mem_addr), 16'(e_addr));
      check($sformatf("v%0d_mem_wdata", i), mem_wdata, e_wd);
      check($sformatf("v%0d_rvalid0", i), 16'(rvalid0), 16'(vt[i].rv0));
      check($sformatf("v%0d_rvalid1", i), 16'(rvalid1), 16'(vt[i].rv1));
      if (vt[i].rv0 || vt[i].rv1)
        check($sformatf("v%0d_rdata", i), rdata, 16'hA5A5 ^ 16'(i));
    end

    // Reset mid-burst: last=1 here, so first make port 0 the last winner.
    @(negedge clk);
    drive(mk(1,0,0,0,0,0, 8'h30, 8'h40, 16'h0, 16'h0, 0,0,0,0));
    #1 check("mb_pre_gnt0", 16'(gnt0), 16'h1);
    for (int unsigned k = 1; k <= 3; k++) begin
      @(negedge clk);
      drive(mk(1,1,0,0,0,1, 8'h30, 8'h40, 16'h0, 16'h0, 0,0,0,0));
      #1;
      check($sformatf("mb_g%0d_gnt1", k), 16'(gnt1), 16'h1);
      check($sformatf("mb_g%0d_addr", k), 16'(mem_addr), 16'h40);
    end
    check("mb_rvalid1_before", 16'(rvalid1), 16'h1);
    #1 rst = 1'b0;
    #1;
    check("mb_async_gnt1", 16'(gnt1), 16'h0);
    check("mb_async_mem_en", 16'(mem_en), 16'h0);
    check("mb_async_rvalid1", 16'(rvalid1), 16'h0);
    @(negedge clk);
    #1;
    check("mb_hold_gnt", {14'h0, gnt1, gnt0}, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mb_after_gnt0", 16'(gnt0), 16'h1);
    check("mb_after_gnt1", 16'(gnt1), 16'h0);
    check("mb_after_addr", 16'(mem_addr), 16'h30);
    @(negedge clk);
    #1;
    check("mb_next_gnt1", 16'(gnt1), 16'h1);
    check("mb_next_rvalid0", 16'(rvalid0), 16'h1);

    idle_inputs();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
